// File: rtl/pipo_pkg.sv
// Shared constants for the serial/parallel word path.
// DATA_W is also the default width of the downstream holding register.
package pipo_pkg;
    localparam int DATA_W = 8;
endpackage

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word output slot and valid/ready handshakes.
// The next word can be shifted in while a completed word waits for the downstream stage.
module sipo_deserializer
    import pipo_pkg::*;
#(
    parameter int N         = DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_sin,
    input  logic                 i_sin_valid,
    output logic                 o_sin_ready,
    output logic [N-1:0]         o_word_out,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic [$clog2(N)-1:0] o_bit_count
);
    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

    logic [N-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_word_out;
    logic          r_word_valid;

    logic          w_free;
    logic          w_last;
    logic          w_acc;
    logic          w_consume;
    logic [N-1:0]  w_nv;

    assign w_free    = !r_word_valid || i_word_ready;
    assign w_last    = (r_cnt == LAST_CNT);
    // word_ready reaches sin_ready combinationally so the final bit can land
    // in the same cycle the pending word drains.
    assign o_sin_ready = !i_clear && !reset && (!w_last || w_free);
    assign w_acc     = i_sin_valid && o_sin_ready;
    assign w_consume = r_word_valid && i_word_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_nv = (r_sr << 1) | {{(N-1){1'b0}}, i_sin};
        end else begin : g_lsb_first
            assign w_nv = (r_sr >> 1) | {i_sin, {(N-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            // Consume first so a completion in the same cycle overrides it.
            if (w_consume) begin
                r_word_valid <= 1'b0;
            end

            if (i_clear) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else if (w_acc) begin
                if (w_last) begin
                    r_word_out   <= w_nv;
                    r_word_valid <= 1'b1;
                    r_sr         <= '0;
                    r_cnt        <= '0;
                end else begin
                    r_sr  <= w_nv;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_word_out   = r_word_out;
    assign o_word_valid = r_word_valid;
    assign o_bit_count  = r_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance share
// one stimulus stream; word-level vector table plus hand-written corner sequences.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset, clear, sin, sin_valid, word_ready;

    logic       rdy_m, vld_m, rdy_l, vld_l;
    logic [7:0] word_m, word_l;
    logic [2:0] cnt_m, cnt_l;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    sipo_deserializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .i_clear(clear), .i_sin(sin), .i_sin_valid(sin_valid),
        .o_sin_ready(rdy_m), .o_word_out(word_m), .o_word_valid(vld_m),
        .i_word_ready(word_ready), .o_bit_count(cnt_m)
    );

    sipo_deserializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .i_clear(clear), .i_sin(sin), .i_sin_valid(sin_valid),
        .o_sin_ready(rdy_l), .o_word_out(word_l), .o_word_valid(vld_l),
        .i_word_ready(word_ready), .o_bit_count(cnt_l)
    );

    typedef struct {
        logic [7:0] bits;      // sent first-bit = bits[7]
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } word_vec_t;

    word_vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic drive(input logic b, input logic v, input logic wr, input logic clr, input logic rs);
        @(negedge clk);
        sin        = b;
        sin_valid  = v;
        word_ready = wr;
        clear      = clr;
        reset      = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] w3c, wc3, w96, w5a;
        int last_cyc;

        tbl[0] = '{bits: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
        tbl[1] = '{bits: 8'h80, exp_msb: 8'h80, exp_lsb: 8'h01};
        tbl[2] = '{bits: 8'hFF, exp_msb: 8'hFF, exp_lsb: 8'hFF};
        tbl[3] = '{bits: 8'h00, exp_msb: 8'h00, exp_lsb: 8'h00};
        tbl[4] = '{bits: 8'h5A, exp_msb: 8'h5A, exp_lsb: 8'h5A};
        w3c = 8'h3C; wc3 = 8'hC3; w96 = 8'h96; w5a = 8'h5A;
        last_cyc = 0;

        reset = 1'b1; clear = 1'b0; sin = 1'b0; sin_valid = 1'b0; word_ready = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_sin_ready", 32'(rdy_m), 32'd0);
        tick(); tick();
        chk("rst_valid", 32'(vld_m), 32'd0);
        chk("rst_word", 32'(word_m), 32'h00);
        chk("rst_cnt", 32'(cnt_m), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_ready", 32'(rdy_m), 32'd1);
        tick();

        // Continuous words, word_ready=1: valid pulses once per 8 cycles, no ready gaps
        for (int w = 0; w < 5; w++) begin
            cur = tbl[w].bits;
            for (int k = 0; k < 8; k++) begin
                drive(cur[7-k], 1'b1, 1'b1, 1'b0, 1'b0);
                chk("stream_ready", 32'(rdy_m), 32'd1);
                tick();
                chk("stream_cnt", 32'(cnt_m), 32'((k + 1) % 8));
                chk("stream_valid", 32'(vld_m), 32'(k == 7));
                if (k == 7) begin
                    chk("stream_word_msb", 32'(word_m), 32'(tbl[w].exp_msb));
                    chk("stream_word_lsb", 32'(word_l), 32'(tbl[w].exp_lsb));
                    chk("stream_valid_lsb", 32'(vld_l), 32'd1);
                    if (w > 0) chk("stream_spacing", 32'(cyc_n - last_cyc), 32'd8);
                    last_cyc = cyc_n;
                end
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("idle_valid", 32'(vld_m), 32'd0);
        chk("idle_word_kept", 32'(word_m), 32'h5A);

        // Back-pressure: 3C waits while C3 fills, final bit stalls until word_ready
        for (int k = 0; k < 8; k++) begin
            drive(w3c[7-k], 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("bp_first_valid", 32'(vld_m), 32'd1);
        chk("bp_first_word", 32'(word_m), 32'h3C);
        chk("bp_first_word_lsb", 32'(word_l), 32'h3C);
        for (int k = 0; k < 7; k++) begin
            drive(wc3[7-k], 1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_fill_ready", 32'(rdy_m), 32'd1);
            tick();
            chk("bp_fill_word_held", 32'(word_m), 32'h3C);
            chk("bp_fill_cnt", 32'(cnt_m), 32'(k + 1));
        end
        drive(wc3[0], 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_ready", 32'(rdy_m), 32'd0);
        tick();
        chk("bp_stall_word", 32'(word_m), 32'h3C);
        chk("bp_stall_valid", 32'(vld_m), 32'd1);
        chk("bp_stall_cnt", 32'(cnt_m), 32'd7);
        drive(wc3[0], 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_release_ready", 32'(rdy_m), 32'd1);
        tick();
        chk("bp_second_word", 32'(word_m), 32'hC3);
        chk("bp_second_word_lsb", 32'(word_l), 32'hC3);
        chk("bp_second_valid", 32'(vld_m), 32'd1);
        chk("bp_second_cnt", 32'(cnt_m), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_drain_valid", 32'(vld_m), 32'd0);
        chk("bp_drain_word", 32'(word_m), 32'hC3);

        // Clear after 4 bits; bit during clear is dropped
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("clr_pre_cnt", 32'(cnt_m), 32'd4);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_ready", 32'(rdy_m), 32'd0);
        tick();
        chk("clr_cnt", 32'(cnt_m), 32'd0);
        chk("clr_valid", 32'(vld_m), 32'd0);
        for (int k = 0; k < 8; k++) begin
            drive(w96[7-k], 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("clr_word_msb", 32'(word_m), 32'h96);
        chk("clr_word_lsb", 32'(word_l), 32'h69);
        chk("clr_word_valid", 32'(vld_m), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset with a pending word and a partial word at cnt=5
        for (int k = 0; k < 8; k++) begin
            drive(w5a[7-k], 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("prerst_valid", 32'(vld_m), 32'd1);
        chk("prerst_cnt", 32'(cnt_m), 32'd5);
        chk("prerst_word", 32'(word_m), 32'h5A);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("midrst_ready", 32'(rdy_m), 32'd0);
        tick();
        chk("midrst_valid", 32'(vld_m), 32'd0);
        chk("midrst_word", 32'(word_m), 32'h00);
        chk("midrst_cnt", 32'(cnt_m), 32'd0);
        chk("midrst_word_lsb", 32'(word_l), 32'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("postrst_ready", 32'(rdy_m), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
